// File: rtl/custom_axi_lite_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_RW byte-strobed control registers, NUM_RO status inputs.
// Optional build macro CUSTOM_AXI_LITE_WPULSE_EN enables the per-register wr_pulse strobe.
module custom_axi_lite_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_RW = 4,
    parameter int NUM_RO = 4,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_RW-1:0]                    wr_pulse
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = AW - ADDR_LSB;
    localparam int NUM_REGS = NUM_RW + NUM_RO;

    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
    typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [STRB_W-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] idx_of(input logic [AW-1:0] addr);
        return 32'(addr[AW-1:ADDR_LSB]);
    endfunction

    function automatic logic [1:0] wr_resp_of(input logic [31:0] idx);
        if (idx < 32'(NUM_RW)) begin
            return 2'b00;
        end else if (idx < 32'(NUM_REGS)) begin
            return 2'b10;
        end else begin
            return 2'b11;
        end
    endfunction

    wr_state_t             wr_state_r, wr_state_s;
    rd_state_t             rd_state_r, rd_state_s;
    logic                  aw_held_r, w_held_r;
    logic [IDX_W-1:0]      awidx_r;
    logic [DW-1:0]         wdata_r;
    logic [STRB_W-1:0]     wstrb_r;
    logic                  bvalid_r, rvalid_r;
    logic [1:0]            bresp_r, rresp_r;
    logic [DW-1:0]         rdata_r;
    logic [DW-1:0]         regs_r [NUM_RW];
    logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s;
    logic [31:0]           wr_idx_s, ar_idx_s;
    logic [DW-1:0]         wr_data_s, rd_data_s;
    logic [STRB_W-1:0]     wr_strb_s;
    logic [1:0]            rd_resp_s;
    logic                  unused_s;

    // Ready depends only on FSM state, held flags and reset, never on the master's valids.
    assign S_AXI_AWREADY = !ARESET && (wr_state_r == WR_IDLE) && !aw_held_r;
    assign S_AXI_WREADY  = !ARESET && (wr_state_r == WR_IDLE) && !w_held_r;
    assign S_AXI_ARREADY = !ARESET && (rd_state_r == RD_IDLE);
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign unused_s      = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_reg_out
        assign reg_out[gi*DW +: DW] = regs_r[gi];
    end

    // Write handshakes, commit detection and write FSM next state.
    always_comb begin
        aw_hs_s   = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs_s    = S_AXI_WVALID && S_AXI_WREADY;
        b_hs_s    = bvalid_r && S_AXI_BREADY;
        commit_s  = (wr_state_r == WR_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
        wr_idx_s  = aw_hs_s ? idx_of(S_AXI_AWADDR) : 32'(awidx_r);
        wr_data_s = w_hs_s ? S_AXI_WDATA : wdata_r;
        wr_strb_s = w_hs_s ? S_AXI_WSTRB : wstrb_r;
        wr_state_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: wr_state_s = commit_s ? WR_RESP : WR_IDLE;
            WR_RESP: wr_state_s = b_hs_s ? WR_IDLE : WR_RESP;
            default: wr_state_s = WR_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_r <= WR_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Held AW/W channels and the B response; a reset drops any half-received write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awidx_r   <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                awidx_r   <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= S_AXI_WDATA;
                wstrb_r  <= S_AXI_WSTRB;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_resp_of(wr_idx_s);
            end else if (b_hs_s) begin
                bvalid_r  <= 1'b0;
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
            end
        end
    end

    // Control registers; only RW indices match, so RO/out-of-range writes change nothing.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_RW; i++) begin
                regs_r[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (commit_s && (wr_idx_s == 32'(i))) begin
                    regs_r[i] <= apply_strb(regs_r[i], wr_data_s, wr_strb_s);
                end
            end
        end
    end

`ifdef CUSTOM_AXI_LITE_WPULSE_EN
    logic [NUM_RW-1:0] wr_pulse_r;

    // One-cycle strobe after every OKAY commit, regardless of WSTRB.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_pulse_r <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                wr_pulse_r[i] <= commit_s && (wr_idx_s == 32'(i));
            end
        end
    end
    assign wr_pulse = wr_pulse_r;
`else
    assign wr_pulse = '0;
`endif

    // Read handshakes, read data mux and read FSM next state.
    always_comb begin
        ar_hs_s   = S_AXI_ARVALID && S_AXI_ARREADY;
        r_hs_s    = rvalid_r && S_AXI_RREADY;
        ar_idx_s  = idx_of(S_AXI_ARADDR);
        rd_data_s = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rd_data_s = (ar_idx_s == 32'(i)) ? regs_r[i] : rd_data_s;
        end
        for (int k = 0; k < NUM_RO; k++) begin
            rd_data_s = (ar_idx_s == 32'(NUM_RW + k)) ? reg_in[k*DW +: DW] : rd_data_s;
        end
        rd_resp_s  = (ar_idx_s < 32'(NUM_REGS)) ? 2'b00 : 2'b11;
        rd_state_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: rd_state_s = ar_hs_s ? RD_DATA : RD_IDLE;
            RD_DATA: rd_state_s = r_hs_s ? RD_IDLE : RD_DATA;
            default: rd_state_s = RD_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_r <= RD_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read response registers, held until the R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= 2'b00;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
        end else if (r_hs_s) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rvalid_r;
        end
    end
endmodule

// File: tb/tb_custom_axi_lite_regbank.sv
// Randomised scoreboard bench for custom_axi_lite_regbank with a word-level reference model.
module tb_custom_axi_lite_regbank;
    localparam int NRW = 4;
    localparam int NRO = 4;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [5:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic        S_AXI_BREADY = 1'b0, S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic [NRW*32-1:0] reg_out;
    logic [NRO*32-1:0] reg_in = '0;
    logic [NRW-1:0]    wr_pulse;

    custom_axi_lite_regbank dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    logic [1:0]  exp_b [$];
    rexp_t       exp_r [$];
    logic [31:0] model_regs [NRW];
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] resp_for(input int idx, input bit is_wr);
        if (idx < NRW) return 2'b00;
        if (idx < NRW + NRO) return is_wr ? 2'b10 : 2'b00;
        return 2'b11;
    endfunction

    task automatic check_reg_out(input string name);
        for (int i = 0; i < NRW; i++) chk(name, reg_out[i*32 +: 32], model_regs[i]);
    endtask

    // Scoreboard monitor: pops the expected response on every B/R handshake.
    always @(negedge ACLK) begin
        if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected: got BRESP %0d with nothing expected", S_AXI_BRESP);
            end else begin
                chk("bresp", S_AXI_BRESP, exp_b.pop_front());
            end
        end
        if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
            if (exp_r.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL r_unexpected: got RDATA 0x%0h with nothing expected", S_AXI_RDATA);
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                chk("rdata", S_AXI_RDATA, e.data);
                chk("rresp", S_AXI_RRESP, e.resp);
            end
        end
    end

    task automatic send_aw(input logic [5:0] addr);
        int n;
        S_AXI_AWADDR = addr; S_AXI_AWPROT = 3'($urandom); S_AXI_AWVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) break;
        end
        chk("aw_handshake", S_AXI_AWREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (S_AXI_WREADY) break;
        end
        chk("w_handshake", S_AXI_WREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] addr);
        int n;
        S_AXI_ARADDR = addr; S_AXI_ARPROT = 3'($urandom); S_AXI_ARVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) break;
        end
        chk("ar_handshake", S_AXI_ARREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic write_txn(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int skew, input int bdelay);
        int idx;
        logic [1:0] resp;
        logic [3:0] exp_pulse;
        idx  = int'(addr[5:2]);
        resp = resp_for(idx, 1'b1);
        if (resp == 2'b00) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        exp_b.push_back(resp);
`ifdef CUSTOM_AXI_LITE_WPULSE_EN
        exp_pulse = (resp == 2'b00) ? (4'b0001 << idx) : 4'b0000;
`else
        exp_pulse = 4'b0000;
`endif
        fork
            begin
                repeat ((skew > 0) ? skew : 0) begin @(posedge ACLK); #1; end
                send_aw(addr);
            end
            begin
                repeat ((skew < 0) ? -skew : 0) begin @(posedge ACLK); #1; end
                send_w(data, strb);
            end
        join
        chk("bvalid_latency", S_AXI_BVALID, 1'b1);
        check_reg_out("reg_out_after_write");
        chk("wr_pulse", wr_pulse, exp_pulse);
        @(posedge ACLK); #1;
        chk("wr_pulse_width", wr_pulse, 4'b0000);
        for (int c = 0; c < bdelay; c++) begin
            chk("bvalid_hold", S_AXI_BVALID, 1'b1);
            chk("bresp_hold", S_AXI_BRESP, resp);
            chk("awready_in_resp", S_AXI_AWREADY, 1'b0);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", S_AXI_BVALID, 1'b0);
    endtask

    task automatic read_txn(input logic [5:0] addr, input int rdelay);
        int idx;
        rexp_t e;
        idx = int'(addr[5:2]);
        e.resp = resp_for(idx, 1'b0);
        if (idx < NRW) e.data = model_regs[idx];
        else if (idx < NRW + NRO) e.data = reg_in[(idx - NRW)*32 +: 32];
        else e.data = 32'h0;
        exp_r.push_back(e);
        send_ar(addr);
        chk("rvalid_latency", S_AXI_RVALID, 1'b1);
        for (int c = 0; c < rdelay; c++) begin
            chk("rvalid_hold", S_AXI_RVALID, 1'b1);
            chk("arready_in_data", S_AXI_ARREADY, 1'b0);
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clear", S_AXI_RVALID, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NRW; i++) model_regs[i] = RV;
        repeat (3) @(posedge ACLK);
        #1;
        chk("awready_in_reset", S_AXI_AWREADY, 1'b0);
        chk("wready_in_reset", S_AXI_WREADY, 1'b0);
        chk("arready_in_reset", S_AXI_ARREADY, 1'b0);
        chk("bvalid_reset", S_AXI_BVALID, 1'b0);
        chk("rvalid_reset", S_AXI_RVALID, 1'b0);
        chk("bresp_reset", S_AXI_BRESP, 2'b00);
        chk("rresp_reset", S_AXI_RRESP, 2'b00);
        chk("rdata_reset", S_AXI_RDATA, 32'h0);
        chk("wr_pulse_reset", wr_pulse, 4'b0000);
        check_reg_out("reg_out_reset");
        ARESET = 1'b0;
        #1;
        chk("awready_after_reset", S_AXI_AWREADY, 1'b1);
        chk("wready_after_reset", S_AXI_WREADY, 1'b1);
        chk("arready_after_reset", S_AXI_ARREADY, 1'b1);
        @(posedge ACLK); #1;

        // Sequential access.
        for (int i = 0; i < 4; i++) write_txn(6'(i*4), 32'(i + 1), 4'b1111, 0, 0);
        for (int i = 0; i < 4; i++) read_txn(6'(i*4), 0);

        // Byte strobes over 0x00000002.
        write_txn(6'h04, 32'hAABBCCDD, 4'b0101, 0, 1);
        chk("strobe_merge", reg_out[63:32], 32'h00BB00DD);
        read_txn(6'h04, 1);

        // Channel skew both ways and B backpressure.
        write_txn(6'h08, 32'h1234_5678, 4'b1111, 3, 5);
        write_txn(6'h0C, 32'hCAFE_F00D, 4'b0011, -3, 2);
        write_txn(6'h00, 32'h0BAD_0001, 4'b0000, 0, 0);

        // Error responses.
        reg_in[31:0] = 32'hDEADBEEF;
        write_txn(6'h10, 32'h5555_5555, 4'b1111, 0, 0);
        chk("ro_reg_in_untouched", reg_in[31:0], 32'hDEADBEEF);
        read_txn(6'h10, 0);
        write_txn(6'h20, 32'h7777_7777, 4'b1111, 1, 0);
        read_txn(6'h20, 2);

        // Read and write active together.
        fork
            write_txn(6'h00, 32'h0F0F_0F0F, 4'b1111, 0, 1);
            read_txn(6'h14, 3);
        join

        // Reset after AW accepted but before W.
        send_aw(6'h08);
        ARESET = 1'b1;
        #1;
        chk("awready_mid_reset", S_AXI_AWREADY, 1'b0);
        repeat (2) @(posedge ACLK);
        #1;
        for (int i = 0; i < NRW; i++) model_regs[i] = RV;
        chk("bvalid_after_abort", S_AXI_BVALID, 1'b0);
        check_reg_out("reg_out_after_abort");
        ARESET = 1'b0;
        #1;
        chk("awready_after_abort", S_AXI_AWREADY, 1'b1);
        @(posedge ACLK); #1;
        write_txn(6'h08, 32'h0000_00A5, 4'b1111, -1, 0);
        read_txn(6'h08, 0);

        // Randomised traffic against the model.
        for (int t = 0; t < 60; t++) begin
            logic [5:0] a;
            a = 6'($urandom);
            for (int k = 0; k < NRO; k++) reg_in[k*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 0)
                write_txn(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            else
                read_txn(a, int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge ACLK);
        #1;
        chk("b_queue_drained", 64'(exp_b.size()), 64'h0);
        chk("r_queue_drained", 64'(exp_r.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
